apb_cmd_sequencer: RTL and testbench
====================================

# apb_cmd_sequencer

Command-queue front end that sits directly upstream of the APB master. It buffers read and write requests from a local requester in a small FIFO and presents them one at a time on the master's request inputs (PSEL, transfer, PWRITE, PADDR, PDATA). It watches the bus handshake (PENABLE, PREADY) to detect completion, captures read data from PRDATA1, and returns one response per command, with a timeout guard against a slave that never becomes ready.

## Interface
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- TIMEOUT, 16: maximum cycles in ACTIVE before a transfer is aborted; minimum 2.
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESET  in  1  reset; asynchronous assert, active-low (0 = reset).
- cmd_valid  in  1  requester has a command.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  target address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester takes the response.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  32  captured read data; 0 for writes and aborted transfers.
- rsp_err  out  1  1 = transfer aborted by timeout.
- PSEL  out  1  to master and slave: transfer selected.
- transfer  out  1  to master: request a transfer.
- PWRITE  out  1  to master and slave: direction.
- PADDR  out  32  to master: address.
- PDATA  out  32  to master: write data.
- PENABLE  in  1  from master: access phase.
- PREADY  in  1  from slave: transfer complete.
- PRDATA1  in  32  from slave: read data.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO push: occurs when cmd_valid && cmd_ready at a clock edge. cmd_ready = (count != DEPTH); there is no bypass path.
- FSM states:
  - IDLE: all bus outputs are 0. If count > 0, pop the head entry into the holding registers and go to ACTIVE.
  - ACTIVE: PSEL = transfer = 1. PWRITE, PADDR and PDATA come from the holding registers and stay stable for the whole state.
    - Completion: PSEL && PENABLE && PREADY sampled at an edge. On completion, capture PRDATA1 into rsp_rdata (reads only), set rsp_err = 0, go to RESP.
    - Abort: if the timeout counter reaches TIMEOUT-1 without completion, set rsp_err = 1 and rsp_rdata = 0, go to RESP.
  - RESP: rsp_valid = 1 and the bus outputs are 0. On rsp_valid && rsp_ready, go to IDLE.
- Timeout counter: cleared on entry to ACTIVE and incremented each cycle in ACTIVE. It is $clog2(TIMEOUT) bits wide and saturates; it never wraps.
- FIFO pointers: $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- Simultaneous push and pop in one cycle: count is unchanged and both operations take effect.
- Push is blocked when count == DEPTH. Pop occurs only in IDLE with count > 0.
- Responses are delivered in command order. Exactly one response is produced per accepted command.

## Timing
- Reset (PRESET = 0, asynchronous):
  - Outputs: PSEL, transfer, PWRITE, rsp_valid, rsp_write, rsp_err = 0; PADDR, PDATA, rsp_rdata = 0; count = 0; cmd_ready = 1.
  - State goes to IDLE and the FIFO is emptied.
  - Reset mid-transfer drops PSEL and transfer immediately; the in-flight command and all queued commands are discarded with no response.
- Command accept to PSEL:
  - A command pushed into an empty FIFO at edge k is popped at edge k+1.
  - PSEL is high from edge k+1, so PSEL rises 1 cycle after the accept edge.
- Completion at edge c:
  - PSEL falls after edge c.
  - rsp_valid is high from edge c until the handshake edge.
- Back-to-back commands: at least one IDLE cycle with PSEL = 0 separates transfers. Minimum period is 4 cycles per command when the slave is zero-wait and rsp_ready is held at 1.
- rsp_* outputs are registered and stable while rsp_valid = 1.
- cmd_ready and count are registered; cmd_ready reflects occupancy as of the previous edge.

## Structure
- Shared package apb_seq_pkg:
  - state enum: IDLE, ACTIVE, RESP.
  - command struct: write, addr[31:0], wdata[31:0].
  - constants DATA_W = 32 and ADDR_W = 32.
- Sub-module cmd_fifo: synchronous FIFO parameterised by DEPTH and the struct width, with push/pop/full/empty/count and async active-low reset.
- The top level holds the FSM, holding registers, timeout counter and response registers.

## Test plan
- Single write: with a bench APB responder that raises PREADY in the access phase, push write addr=0x2 data=0xF. Required: PSEL rises 1 cycle after the accept; PADDR=0x2, PDATA=0xF, PWRITE=1 stable while PSEL=1; one response with rsp_write=1, rsp_err=0, rsp_rdata=0.
- Single read: push read addr=0x2 with the responder driving PRDATA1=0x8000_0003. Required: rsp_rdata=0x8000_0003, rsp_write=0.
- Fill and drain: push 5 commands with DEPTH=4 while rsp_ready=0. Required: cmd_ready=0 once count=4; after rsp_ready=1, responses come back in push order; count returns to 0.
- Timeout: hold PREADY=0. Required: PSEL falls after exactly TIMEOUT cycles in ACTIVE; response has rsp_err=1 and rsp_rdata=0; the next queued command then proceeds normally.
- Backpressure and simultaneity: rsp_ready=0 for 10 cycles, then push and pop the FIFO in the same cycle. Required: rsp fields stay stable and count is unchanged across the simultaneous push/pop.
- Reset mid-transfer: assert PRESET=0 while PSEL=1 with 2 commands queued. Required: PSEL=0 immediately, count=0, no response after reset is released.

Source files
------------

// File: rtl/apb_cmd_sequencer_pkg.sv
// Shared types and constants for the APB command sequencer: FSM states,
// the queued command record and bus widths.
package apb_seq_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// Requester command/response channels, APB master request/handshake signals
// and FIFO occupancy. The sequencer connects through the slave modport.
interface apb_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  import apb_seq_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              transfer;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PDATA;
  logic              PENABLE;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA1;

  logic [CNT_W-1:0]  count;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  PENABLE, PREADY, PRDATA1,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output PSEL, transfer, PWRITE, PADDR, PDATA,
    output count
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready,
    output PENABLE, PREADY, PRDATA1,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  PSEL, transfer, PWRITE, PADDR, PDATA,
    input  count
  );

endinterface

// File: rtl/apb_cmd_sequencer_cmd_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout whenever
// the FIFO is non-empty, so the consumer can capture it on the pop edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Command-queue front end for an APB master: queues requests, issues them one
// at a time, detects completion or timeout and returns one response each.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_cmd_sequencer_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  cmd_t                fifo_din;
  cmd_t                fifo_dout;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pdata_q, pdata_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                xfer_done;

  assign fifo_din.write = bus.cmd_write;
  assign fifo_din.addr  = bus.cmd_addr;
  assign fifo_din.wdata = bus.cmd_wdata;
  assign fifo_push      = bus.cmd_valid && !fifo_full;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (PCLK),
    .rst_n (PRESET),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.cmd_ready = !fifo_full;
  assign bus.count     = fifo_count;
  assign bus.PSEL      = psel_q;
  assign bus.transfer  = psel_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PDATA     = pdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign xfer_done = psel_q && bus.PENABLE && bus.PREADY;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ACTIVE;
          psel_d   = 1'b1;
          pwrite_d = fifo_dout.write;
          paddr_d  = fifo_dout.addr;
          pdata_d  = fifo_dout.wdata;
          tmo_d    = '0;
        end
      end

      ACTIVE: begin
        if (xfer_done || (tmo_q == TMO_LAST)) begin
          // Bus request drops and the response is launched on the same edge.
          state_d     = RESP;
          psel_d      = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pdata_d     = '0;
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_err_d   = !xfer_done;
          rsp_rdata_d = (xfer_done && !pwrite_q) ? bus.PRDATA1 : '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        psel_d      = 1'b0;
        pwrite_d    = 1'b0;
        paddr_d     = '0;
        pdata_d     = '0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed testbench for apb_cmd_sequencer with a small APB master/slave
// responder model; each scenario task checks its own hand-computed values.
module tb_apb_cmd_sequencer;
  import apb_seq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic        pready_en = 1'b0;
  logic        rd_mode = 1'b0;
  logic [31:0] prdata_val = 32'h0;
  logic        penable_q;

  apb_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  apb_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Access phase follows the setup cycle; it ends on PREADY or when PSEL drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) penable_q <= 1'b0;
    else if (bus.PSEL && !penable_q) penable_q <= 1'b1;
    else if (penable_q && (bus.PREADY || !bus.PSEL)) penable_q <= 1'b0;
  end

  assign bus.PENABLE = penable_q;
  assign bus.PREADY  = pready_en && penable_q;
  assign bus.PRDATA1 = rd_mode ? (bus.PADDR ^ 32'h5A5A_0000) : prdata_val;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_accept addr=%h: cmd_ready=%b required 1", a, bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.PSEL, bus.transfer, bus.PWRITE, bus.rsp_valid, bus.rsp_write, bus.rsp_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {bus.PSEL, bus.transfer, bus.PWRITE, bus.rsp_valid, bus.rsp_write, bus.rsp_err});
    end
    checks++;
    if (bus.PADDR !== 32'h0 || bus.PDATA !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: PADDR=%h PDATA=%h rsp_rdata=%h required 0", bus.PADDR, bus.PDATA, bus.rsp_rdata);
    end
    checks++;
    if (bus.count !== 3'd0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_fifo: count=%0d cmd_ready=%b required 0/1", bus.count, bus.cmd_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.PSEL !== 1'b0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL reset_release_idle: PSEL=%b count=%0d required 0/0", bus.PSEL, bus.count);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    bus.rsp_ready = 1'b1;
    pready_en = 1'b1;
    push(1'b1, 32'h2, 32'hF);
    checks++;
    if (bus.PSEL !== 1'b0 || bus.count !== 3'd1) begin
      failures++;
      $display("FAIL wr_accept_edge: PSEL=%b count=%0d required 0/1", bus.PSEL, bus.count);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.PSEL, bus.transfer, bus.PWRITE} !== 3'b111 || bus.PADDR !== 32'h2 || bus.PDATA !== 32'hF) begin
        failures++;
        $display("FAIL wr_bus_cycle%0d: sel/xfer/wr=%b PADDR=%h PDATA=%h required 111/2/f",
                 i, {bus.PSEL, bus.transfer, bus.PWRITE}, bus.PADDR, bus.PDATA);
      end
    end
    tick();
    checks++;
    if (bus.PSEL !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_complete: PSEL=%b rsp_valid=%b required 0/1", bus.PSEL, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_write !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_rsp: write=%b err=%b rdata=%h required 1/0/0", bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL wr_handshake: rsp_valid=%b count=%0d required 0/0", bus.rsp_valid, bus.count);
    end
    $display("test_single_write done");
  endtask

  task automatic test_single_read();
    rd_mode = 1'b0;
    prdata_val = 32'h8000_0003;
    push(1'b0, 32'h2, 32'h0);
    tick();
    checks++;
    if (bus.PSEL !== 1'b1 || bus.PWRITE !== 1'b0 || bus.PADDR !== 32'h2) begin
      failures++;
      $display("FAIL rd_bus: PSEL=%b PWRITE=%b PADDR=%h required 1/0/2", bus.PSEL, bus.PWRITE, bus.PADDR);
    end
    tick();
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h8000_0003) begin
      failures++;
      $display("FAIL rd_rsp: valid=%b write=%b err=%b rdata=%h required 1/0/0/80000003",
               bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
    $display("test_single_read done");
  endtask

  task automatic test_back_to_back();
    logic [4:0] seen;
    seen = '0;
    push(1'b1, 32'h30, 32'h1);
    push(1'b1, 32'h34, 32'h2);
    for (int i = 0; i < 5; i++) begin
      seen[i] = bus.PSEL;
      if (i < 4) tick();
    end
    checks++;
    if (seen !== 5'b10011 || bus.PADDR !== 32'h34) begin
      failures++;
      $display("FAIL b2b_period: PSEL pattern=%b PADDR=%h required 10011/34", seen, bus.PADDR);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.PSEL !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL b2b_drain: PSEL=%b rsp_valid=%b count=%0d required 0/0/0", bus.PSEL, bus.rsp_valid, bus.count);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_fill_drain();
    logic        cw [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ca [5] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    logic [31:0] er [5] = '{32'h0, 32'h5A5A_0014, 32'h0, 32'h5A5A_001C, 32'h5A5A_0020};
    int got;
    int n;
    bus.rsp_ready = 1'b0;
    rd_mode = 1'b1;
    for (int i = 0; i < 5; i++) push(cw[i], ca[i], 32'h100 + i);
    checks++;
    if (bus.count !== 3'd4 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: count=%0d cmd_ready=%b required 4/0", bus.count, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'hEE;
    for (int i = 0; i < 3; i++) tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd4 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_blocked: count=%0d cmd_ready=%b required 4/0", bus.count, bus.cmd_ready);
    end
    bus.rsp_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 5 && n < 200) begin
      if (bus.rsp_valid) begin
        checks++;
        if (bus.rsp_write !== cw[got] || bus.rsp_rdata !== er[got] || bus.rsp_err !== 1'b0) begin
          failures++;
          $display("FAIL drain_rsp%0d: write=%b rdata=%h err=%b required %b/%h/0",
                   got, bus.rsp_write, bus.rsp_rdata, bus.rsp_err, cw[got], er[got]);
        end
        got++;
      end
      if (got < 5) tick();
      n++;
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL drain_count: responses=%0d required 5", got);
    end
    tick();
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: count=%0d rsp_valid=%b required 0/0", bus.count, bus.rsp_valid);
    end
    rd_mode = 1'b0;
    $display("test_fill_drain done");
  endtask

  task automatic test_timeout();
    int n;
    bus.rsp_ready = 1'b1;
    pready_en = 1'b0;
    push(1'b1, 32'h40, 32'hAA);
    push(1'b1, 32'h44, 32'hBB);
    n = 0;
    while (bus.PSEL && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != TIMEOUT) begin
      failures++;
      $display("FAIL tmo_cycles: PSEL high %0d cycles required %0d", n, TIMEOUT);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_write !== 1'b1) begin
      failures++;
      $display("FAIL tmo_rsp: valid=%b err=%b rdata=%h write=%b required 1/1/0/1",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.rsp_write);
    end
    pready_en = 1'b1;
    n = 0;
    tick();
    while (!bus.PSEL && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.PSEL !== 1'b1 || bus.PADDR !== 32'h44) begin
      failures++;
      $display("FAIL tmo_next_issue: PSEL=%b PADDR=%h required 1/44", bus.PSEL, bus.PADDR);
    end
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_write !== 1'b1) begin
      failures++;
      $display("FAIL tmo_next_rsp: valid=%b err=%b write=%b required 1/0/1", bus.rsp_valid, bus.rsp_err, bus.rsp_write);
    end
    tick();
    $display("test_timeout done");
  endtask

  task automatic test_backpressure();
    int n;
    bus.rsp_ready = 1'b0;
    pready_en = 1'b1;
    prdata_val = 32'h1234_5678;
    push(1'b0, 32'h50, 32'h0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    push(1'b1, 32'h54, 32'h99);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'h1234_5678 ||
          bus.rsp_err !== 1'b0 || bus.count !== 3'd1) begin
        failures++;
        $display("FAIL bp_stable%0d: valid=%b write=%b rdata=%h err=%b count=%0d required 1/0/12345678/0/1",
                 i, bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_err, bus.count);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.count !== 3'd1 || bus.PSEL !== 1'b0) begin
      failures++;
      $display("FAIL bp_handshake: valid=%b count=%0d PSEL=%b required 0/1/0", bus.rsp_valid, bus.count, bus.PSEL);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h58;
    bus.cmd_wdata = 32'h0;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd1 || bus.PSEL !== 1'b1 || bus.PADDR !== 32'h54) begin
      failures++;
      $display("FAIL bp_push_pop: count=%0d PSEL=%b PADDR=%h required 1/1/54", bus.count, bus.PSEL, bus.PADDR);
    end
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL bp_rsp_y: valid=%b write=%b rdata=%h required 1/1/0", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata);
    end
    tick();
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bp_rsp_z: valid=%b write=%b rdata=%h required 1/0/12345678", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata);
    end
    tick();
    checks++;
    if (bus.count !== 3'd0) begin
      failures++;
      $display("FAIL bp_empty: count=%0d required 0", bus.count);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.rsp_ready = 1'b1;
    pready_en = 1'b0;
    push(1'b1, 32'h60, 32'h1);
    push(1'b1, 32'h64, 32'h2);
    push(1'b0, 32'h68, 32'h3);
    checks++;
    if (bus.PSEL !== 1'b1 || bus.count !== 3'd2) begin
      failures++;
      $display("FAIL rstmid_setup: PSEL=%b count=%0d required 1/2", bus.PSEL, bus.count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.PSEL !== 1'b0 || bus.transfer !== 1'b0 || bus.count !== 3'd0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async: PSEL=%b transfer=%b count=%0d cmd_ready=%b required 0/0/0/1",
               bus.PSEL, bus.transfer, bus.count, bus.cmd_ready);
    end
    tick();
    rst_n = 1'b1;
    pready_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.rsp_valid || bus.PSEL) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_rsp: activity after reset=%b required 0", seen);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_fill_drain();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
